// File: rtl/sid_i2s_tx.sv
// Philips I2S transmitter for the SID stereo sample stream.
// Generates BCK/LRCK/SDATA from clk and latches both channels together once per frame.

package sid;
    typedef struct packed {
        logic signed [23:0] left;
        logic signed [23:0] right;
    } audio_t;
endpackage

module sid_i2s_tx #(
    parameter int BCK_HALF  = 4,
    parameter int SLOT_BITS = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  sid::audio_t  audio_i,
    output logic         bck,
    output logic         lrck,
    output logic         sdata,
    output logic         sample_tick
);
    localparam int FRAME_BITS = 2 * SLOT_BITS;
    localparam int DIV_W      = (BCK_HALF > 1) ? $clog2(BCK_HALF) : 1;
    localparam int CNT_W      = $clog2(FRAME_BITS);

    logic [DIV_W-1:0]      r_div_cnt;
    logic [CNT_W-1:0]      r_bit_cnt;
    logic [FRAME_BITS-1:0] r_shift;
    logic                  r_bck;
    logic                  r_lrck;
    logic                  r_sdata;
    logic                  r_tick;

    logic                      w_div_end;
    logic                      w_fall;
    logic                      w_wrap;
    logic [CNT_W-1:0]          w_bit_nxt;
    logic [SLOT_BITS+23:0]     w_left_ext;
    logic [SLOT_BITS+23:0]     w_right_ext;
    logic [FRAME_BITS-1:0]     w_frame;

    assign w_div_end = (r_div_cnt == DIV_W'(BCK_HALF - 1));
    assign w_fall    = w_div_end && r_bck;
    assign w_wrap    = (r_bit_cnt == CNT_W'(FRAME_BITS - 1));
    assign w_bit_nxt = w_wrap ? '0 : r_bit_cnt + 1'b1;

    // Each channel is left-justified in its slot; padding appended without zero-width replication.
    assign w_left_ext  = {audio_i.left,  {SLOT_BITS{1'b0}}};
    assign w_right_ext = {audio_i.right, {SLOT_BITS{1'b0}}};
    assign w_frame     = {w_left_ext[SLOT_BITS+23 -: SLOT_BITS],
                          w_right_ext[SLOT_BITS+23 -: SLOT_BITS]};

    always_ff @(posedge clk) begin
        if (rst) begin
            r_div_cnt <= '0;
            r_bck     <= 1'b0;
            r_bit_cnt <= CNT_W'(FRAME_BITS - 1);
            r_shift   <= '0;
            r_lrck    <= 1'b0;
            r_sdata   <= 1'b0;
            r_tick    <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (w_div_end) begin
                r_div_cnt <= '0;
                r_bck     <= ~r_bck;
            end else begin
                r_div_cnt <= r_div_cnt + 1'b1;
            end
            if (w_fall) begin
                r_bit_cnt <= w_bit_nxt;
                r_lrck    <= (w_bit_nxt >= CNT_W'(SLOT_BITS));
                // r_sdata is the one-BCK I2S delay: the previous frame's LSB goes out at the wrap.
                r_sdata   <= r_shift[FRAME_BITS-1];
                if (w_wrap) begin
                    r_shift <= w_frame;
                    r_tick  <= 1'b1;
                end else begin
                    r_shift <= {r_shift[FRAME_BITS-2:0], 1'b0};
                end
            end
        end
    end

    assign bck         = r_bck;
    assign lrck        = r_lrck;
    assign sdata       = r_sdata;
    assign sample_tick = r_tick;
endmodule
